// File: rtl/tap_pkg.sv
// Shared definitions for the TAP controller: one-hot state encoding,
// instruction opcodes and the default instruction register width.
package tap_pkg;

    localparam int IR_W_DEF = 4;

    localparam logic [3:0] OP_EXTEST  = 4'b0000;
    localparam logic [3:0] OP_SAMPLE  = 4'b0001;
    localparam logic [3:0] OP_RUNBIST = 4'b0010;
    localparam logic [3:0] OP_BYPASS  = 4'b1111;

    // One-hot so the combinational decodes off the state register cannot glitch.
    typedef enum logic [15:0] {
        TLR    = 16'h0001,
        RTI    = 16'h0002,
        SEL_DR = 16'h0004,
        CAP_DR = 16'h0008,
        SH_DR  = 16'h0010,
        EX1_DR = 16'h0020,
        PAU_DR = 16'h0040,
        EX2_DR = 16'h0080,
        UPD_DR = 16'h0100,
        SEL_IR = 16'h0200,
        CAP_IR = 16'h0400,
        SH_IR  = 16'h0800,
        EX1_IR = 16'h1000,
        PAU_IR = 16'h2000,
        EX2_IR = 16'h4000,
        UPD_IR = 16'h8000
    } tap_state_e;

endpackage

// File: rtl/tap_fsm.sv
// 16-state TAP machine driven by tms on each rising clock edge.
//
// state  | meaning
// TLR    | test-logic-reset, IR forced to BYPASS
// RTI    | run-test/idle, BIST runs here when selected
// SEL_DR | select DR scan branch
// CAP_DR | capture into selected data register
// SH_DR  | shift selected data register
// EX1_DR | exit-1 of DR scan
// PAU_DR | pause DR scan, registers hold
// EX2_DR | exit-2 of DR scan
// UPD_DR | update DR (BSR update strobe follows)
// SEL_IR | select IR scan branch
// CAP_IR | capture 0..01 into IR shift register
// SH_IR  | shift IR shift register
// EX1_IR | exit-1 of IR scan
// PAU_IR | pause IR scan, registers hold
// EX2_IR | exit-2 of IR scan
// UPD_IR | update instruction from IR shift register
module tap_fsm
    import tap_pkg::*;
(
    input  logic       clock,
    input  logic       rst_l,
    input  logic       tms,
    output tap_state_e state_o,
    output tap_state_e state_nxt_o
);

    tap_state_e state_q;
    tap_state_e state_d;

    // State register, async reset into Test-Logic-Reset.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) state_q <= TLR;
        else        state_q <= state_d;
    end

    // Standard TAP transitions on tms.
    always_comb begin
        state_d = TLR;
        case (state_q)
            TLR:     state_d = tms ? TLR    : RTI;
            RTI:     state_d = tms ? SEL_DR : RTI;
            SEL_DR:  state_d = tms ? SEL_IR : CAP_DR;
            CAP_DR:  state_d = tms ? EX1_DR : SH_DR;
            SH_DR:   state_d = tms ? EX1_DR : SH_DR;
            EX1_DR:  state_d = tms ? UPD_DR : PAU_DR;
            PAU_DR:  state_d = tms ? EX2_DR : PAU_DR;
            EX2_DR:  state_d = tms ? UPD_DR : SH_DR;
            UPD_DR:  state_d = tms ? SEL_DR : RTI;
            SEL_IR:  state_d = tms ? TLR    : CAP_IR;
            CAP_IR:  state_d = tms ? EX1_IR : SH_IR;
            SH_IR:   state_d = tms ? EX1_IR : SH_IR;
            EX1_IR:  state_d = tms ? UPD_IR : PAU_IR;
            PAU_IR:  state_d = tms ? EX2_IR : PAU_IR;
            EX2_IR:  state_d = tms ? UPD_IR : SH_IR;
            UPD_IR:  state_d = tms ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    assign state_o     = state_q;
    assign state_nxt_o = state_d;

endmodule

// File: rtl/tap_ctrl.sv
// TAP controller top: instruction register, bypass bit, BSR control decode
// and the falling-edge tdo register.
module tap_ctrl
    import tap_pkg::*;
#(
    parameter int IR_W = IR_W_DEF
) (
    input  logic            clock,
    input  logic            rst_l,
    input  logic            tms,
    input  logic            tdi,
    input  logic            bsr_so,
    output logic            bsr_si,
    output logic            tdo,
    output logic            tdo_en,
    output logic            dr_shift,
    output logic            dr_capture,
    output logic            dr_update,
    output logic            bsr_en,
    output logic            bist_run,
    output logic [IR_W-1:0] ir_q
);

    localparam logic [IR_W-1:0] IR_CAPTURE  = {{(IR_W-1){1'b0}}, 1'b1};
    localparam logic [IR_W-1:0] OP_BYPASS_W = {IR_W{1'b1}};
    localparam logic [IR_W-1:0] OP_EXTEST_W = IR_W'(OP_EXTEST);
    localparam logic [IR_W-1:0] OP_SAMPLE_W = IR_W'(OP_SAMPLE);
    localparam logic [IR_W-1:0] OP_RBIST_W  = IR_W'(OP_RUNBIST);

    tap_state_e      state;
    tap_state_e      state_nxt;
    logic [IR_W-1:0] ir_sr_q, ir_sr_d;
    logic [IR_W-1:0] ir_d;
    logic            bypass_q, bypass_d;
    logic            dr_update_q;
    logic            tdo_q, tdo_d;
    logic            bsr_sel;

    tap_fsm u_fsm (
        .clock       (clock),
        .rst_l       (rst_l),
        .tms         (tms),
        .state_o     (state),
        .state_nxt_o (state_nxt)
    );

    // Any opcode other than EXTEST/SAMPLE routes DR scans through bypass.
    assign bsr_sel    = (ir_q == OP_EXTEST_W) || (ir_q == OP_SAMPLE_W);
    assign bsr_si     = tdi;
    assign tdo_en     = (state == SH_DR) || (state == SH_IR);
    assign dr_shift   = bsr_sel && (state == SH_DR);
    assign dr_capture = bsr_sel && ((state == CAP_DR) || (state == SH_DR));
    assign bsr_en     = (ir_q == OP_EXTEST_W);
    assign bist_run   = (ir_q == OP_RBIST_W) && (state == RTI);
    assign dr_update  = dr_update_q;
    assign tdo        = tdo_q;

    // Next values for the scan registers and the instruction.
    always_comb begin
        ir_sr_d  = ir_sr_q;
        bypass_d = bypass_q;
        ir_d     = ir_q;
        if (state == CAP_IR)     ir_sr_d = IR_CAPTURE;
        else if (state == SH_IR) ir_sr_d = {tdi, ir_sr_q[IR_W-1:1]};
        if (state == CAP_DR)     bypass_d = 1'b0;
        else if (state == SH_DR) bypass_d = tdi;
        // Loading BYPASS on entry to TLR makes ir_q valid for the whole TLR stay.
        if (state_nxt == TLR)     ir_d = OP_BYPASS_W;
        else if (state == UPD_IR) ir_d = ir_sr_q;
    end

    // Serial-out source for the current shift state; 0 outside shifting.
    always_comb begin
        tdo_d = 1'b0;
        if (state == SH_IR)      tdo_d = ir_sr_q[0];
        else if (state == SH_DR) tdo_d = bsr_sel ? bsr_so : bypass_q;
    end

    // Rising-edge registers: IR shift, instruction, bypass and update strobe.
    always_ff @(posedge clock or negedge rst_l) begin
        if (!rst_l) begin
            ir_sr_q     <= '0;
            ir_q        <= OP_BYPASS_W;
            bypass_q    <= 1'b0;
            dr_update_q <= 1'b0;
        end else begin
            ir_sr_q     <= ir_sr_d;
            ir_q        <= ir_d;
            bypass_q    <= bypass_d;
            dr_update_q <= bsr_sel && (state == UPD_DR);
        end
    end

    // tdo launched on the falling edge so the tester samples it on the next rise.
    always_ff @(negedge clock or negedge rst_l) begin
        if (!rst_l) tdo_q <= 1'b0;
        else        tdo_q <= tdo_d;
    end

endmodule

// File: doc/tap_ctrl.md
# tap_ctrl

IEEE 1149.1-style test access port controller that drives the boundary-scan and scan-DFF cells of the test-logic chain. It decodes TMS into the standard 16-state TAP machine and holds the instruction register. It generates the per-chain shift/capture/update/enable controls consumed by the BSR and scan cells, and muxes the selected chain's serial output to TDO. It sits directly upstream of the boundary-scan register chain and its scan-in.

## Interface
- IR_W, 4: instruction register width (≥2)
- OP_EXTEST, 4'b0000: drive pins from the BSR (bsr_en=1), BSR chain selected
- OP_SAMPLE, 4'b0001: BSR chain selected, bsr_en=0
- OP_RUNBIST, 4'b0010: bist_run asserted in Run-Test/Idle, bypass chain selected
- OP_BYPASS, 4'b1111: 1-bit bypass register selected; all undefined opcodes behave as BYPASS
- clock  in  1  TCK; all logic on rising edge except tdo (falling edge)
- rst_l  in  1  asynchronous active-low reset; forces Test-Logic-Reset
- tms  in  1  TAP mode select
- tdi  in  1  serial data in; feeds IR, bypass and BSR chain scan-in
- bsr_so  in  1  scan_out of last BSR cell
- bsr_si  out  1  scan-in to first BSR cell (= tdi)
- tdo  out  1  serial data out
- tdo_en  out  1  high while in Shift-DR or Shift-IR
- dr_shift  out  1  BSR shift/sel select: scan-in vs functional data
- dr_capture  out  1  BSR flop enable (hold when low)
- dr_update  out  1  BSR update strobe (used as update clock)
- bsr_en  out  1  BSR output mux select: scanned data vs functional
- bist_run  out  1  BIST enable toward the BILBO controller
- ir_q  out  IR_W  current instruction

## Operation
- States: TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR. Transitions follow 1149.1 exactly on tms at each rising edge (e.g. TLR→RTI on tms=0, UPD_*→SEL_DR on tms=1, →RTI on tms=0).
- Five consecutive tms=1 clocks reach TLR from any state.
- IR shift register: in CAP_IR loads {0…0,01}; in SH_IR shifts right with tdi into MSB. In UPD_IR the value copies into ir_q. In TLR ir_q=OP_BYPASS.
- Bypass register: loads 0 in CAP_DR; loads tdi in SH_DR.
- bsr_sel = (ir_q==OP_EXTEST)||(ir_q==OP_SAMPLE).
- dr_shift = bsr_sel && state==SH_DR.
- dr_capture = bsr_sel && state∈{CAP_DR,SH_DR}. Low in every other state so BSR cells hold.
- dr_update: registered. High for exactly one clock, the cycle after the FSM is in UPD_DR with bsr_sel=1.
- bsr_en = (ir_q==OP_EXTEST); it changes only at UPD_IR or reset.
- bist_run = (ir_q==OP_RUNBIST) && state==RTI.
- tdo source: SH_IR→IR shift LSB; SH_DR→bsr_so if bsr_sel, else bypass bit. Otherwise tdo holds 0.

## Timing
- Reset (rst_l=0, async): state=TLR, ir_q=OP_BYPASS, IR shift=0, bypass=0, tdo=0, tdo_en=0, dr_update=0. All other outputs decode to 0.
- State-decoded outputs (dr_shift, dr_capture, bsr_en, bist_run, tdo_en) are combinational from registered state/ir_q; glitch-free because the encoding is one-hot.
- tdo is registered on the falling edge of clock. The value is valid half a cycle after entering a shift state and is 0 in the half-cycle after leaving it.
- IR path latency: IR_W SH_IR clocks fill the IR. ir_q changes on the rising edge that leaves UPD_IR.
- Bypass latency: tdi→tdo is 1 SH_DR clock plus the half-cycle falling-edge register.
- rst_l asserted mid-shift: partial IR data is discarded, ir_q→BYPASS, and bsr_en drops immediately.
- PAU_DR/PAU_IR: all shift registers hold and dr_capture=0.

## Structure
- Package tap_pkg: one-hot state encoding constants and opcode constants (OP_*), plus IR_W default.
- Sub-module tap_fsm: state register plus 16-state next-state logic, exporting state. tap_ctrl holds the IR, bypass, output decode and the tdo register.

## Test plan
- Reset, then tms=1 ×5 from RUNBIST state → state=TLR, ir_q=4'b1111, bsr_en=0, tdo=0.
- Load IR=0000 (tms 0,1,1,0,0, shift tdi 0,0,0,0 with last tms=1, then tms 1,0) → ir_q=0000, bsr_en=1. TDO during SH_IR = 1,0,0,0 (captured 0001).
- EXTEST DR scan of 8-bit chain model, shifting 8'hA5 → dr_capture high in CAP_DR plus 8 SH_DR cycles, dr_shift high 8 cycles, one dr_update pulse, chain holds 8'hA5.
- BYPASS with tdi pattern 1,0,1,1 through SH_DR → tdo 0,1,0,1,1 (leading captured 0).
- Load RUNBIST, go to RTI for 10 clocks → bist_run=1 for exactly those 10 cycles, 0 on exit to SEL_DR.
- Assert rst_l mid SH_IR after 2 bits → ir_q=1111, state=TLR asynchronously, no dr_update pulse.
